// File: rtl/exp_addsub_pipe.sv
// Two-stage pipelined exponent adder/subtractor with bias modes for FP multiply/divide,
// valid/ready flow control, optional saturation and a saturating out-of-range counter.
module exp_addsub_pipe #(
  parameter int EXP_W = 6,
  parameter int BIAS  = 15,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic             ovf,
  output logic             unf,
  output logic [7:0]       ovf_cnt,
  input  logic             cnt_clr
);

  // Three guard bits hold 3*(2^EXP_W-1) and -2*(2^EXP_W-1) without wrap.
  localparam int W = EXP_W + 3;
  localparam logic signed [W-1:0] MAX_V  = W'((1 << EXP_W) - 1);
  localparam logic signed [W-1:0] BIAS_V = W'(BIAS);

  logic                    s1_valid;
  logic signed [W-1:0]     s1_raw;
  logic [1:0]              s1_mode;
  logic                    s2_valid;
  logic [EXP_W-1:0]        s2_exp;
  logic                    s2_ovf;
  logic                    s2_unf;
  logic [7:0]              cnt;

  logic                    s1_load;
  logic                    s2_load;
  logic [W-1:0]            a_ext;
  logic [W-1:0]            b_ext;
  logic signed [W-1:0]     raw;
  logic signed [W-1:0]     adj;
  logic                    adj_ovf;
  logic                    adj_unf;
  logic [EXP_W-1:0]        adj_exp;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  assign a_ext = W'(exp_a);
  assign b_ext = W'(exp_b);
  assign raw   = mode[0] ? (a_ext + ~b_ext + W'(1)) : (a_ext + b_ext);

  always_comb begin
    adj = s1_raw;
    case (s1_mode)
      2'b10:   adj = s1_raw - BIAS_V;
      2'b11:   adj = s1_raw + BIAS_V;
      default: adj = s1_raw;
    endcase
    adj_unf = adj[W-1];
    adj_ovf = adj > MAX_V;
    adj_exp = adj[EXP_W-1:0];
    if (SAT != 0) begin
      if (adj_ovf)      adj_exp = '1;
      else if (adj_unf) adj_exp = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_mode  <= 2'b00;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_raw   <= raw;
      s1_mode  <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_exp   <= '0;
      s2_ovf   <= 1'b0;
      s2_unf   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      s2_exp   <= adj_exp;
      s2_ovf   <= adj_ovf;
      s2_unf   <= adj_unf;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (cnt_clr) begin
      cnt <= 8'd0;
    end else if (s2_valid && out_ready && (s2_ovf || s2_unf) && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign out_valid = s2_valid;
  assign exp_out   = s2_exp;
  assign ovf       = s2_ovf;
  assign unf       = s2_unf;
  assign ovf_cnt   = cnt;

endmodule

// File: tb/tb_exp_addsub_pipe.sv
// Bench for exp_addsub_pipe: directed literal cases plus randomized traffic checked against
// an arithmetic reference model; a second instance runs with SAT=0 on the same inputs.
module tb_exp_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] exp_a = '0;
  logic [5:0] exp_b = '0;
  logic [1:0] mode = 2'b00;
  logic       out_ready = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       in_ready, out_valid, ovf, unf;
  logic [5:0] exp_out;
  logic [7:0] ovf_cnt;
  logic       in_ready0, out_valid0, ovf0, unf0;
  logic [5:0] exp_out0;
  logic [7:0] ovf_cnt0;

  exp_addsub_pipe #(.EXP_W(6), .BIAS(15), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .exp_out(exp_out), .ovf(ovf), .unf(unf),
    .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  exp_addsub_pipe #(.EXP_W(6), .BIAS(15), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .exp_a(exp_a), .exp_b(exp_b), .mode(mode), .out_valid(out_valid0),
    .out_ready(out_ready), .exp_out(exp_out0), .ovf(ovf0), .unf(unf0),
    .ovf_cnt(ovf_cnt0), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;   // saturated result
    int w;   // wrapped result
    bit o;
    bit u;
  } beat_t;

  beat_t exp_q[$];
  int    delivered[$];
  int    cnt_m = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic beat_t model(input int a, input int b, input int m);
    beat_t r;
    int v;
    v = (m % 2 == 1) ? a - b : a + b;
    if (m == 2) v = v - 15;
    if (m == 3) v = v + 15;
    r.o = (v > 63);
    r.u = (v < 0);
    r.w = v & 63;
    r.e = r.o ? 63 : (r.u ? 0 : v);
    return r;
  endfunction

  // Scoreboard: checks every output cycle, tracks counter, records accepted inputs.
  always @(negedge clk) begin
    beat_t e;
    bit    flagged;
    if (!rst_n) begin
      exp_q.delete();
      cnt_m = 0;
    end else begin
      chk("ovf_cnt", int'(ovf_cnt), cnt_m);
      chk("ovf_cnt_wrapinst", int'(ovf_cnt0), cnt_m);
      chk("in_ready_wrapinst", int'(in_ready0), int'(in_ready));
      chk("out_valid_wrapinst", int'(out_valid0), int'(out_valid));
      flagged = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat: out_valid=1 exp_out=%0d with no beat pending", exp_out);
        end else begin
          e = exp_q[0];
          chk("exp_out", int'(exp_out), e.e);
          chk("ovf", int'(ovf), int'(e.o));
          chk("unf", int'(unf), int'(e.u));
          chk("exp_out_wrap", int'(exp_out0), e.w);
          chk("ovf_wrap", int'(ovf0), int'(e.o));
          chk("unf_wrap", int'(unf0), int'(e.u));
          if (out_ready) begin
            delivered.push_back(int'(exp_out));
            flagged = e.o || e.u;
            void'(exp_q.pop_front());
          end
        end
      end
      if (cnt_clr) cnt_m = 0;
      else if (flagged && cnt_m < 255) cnt_m = cnt_m + 1;
      if (in_valid && in_ready)
        exp_q.push_back(model(int'(exp_a), int'(exp_b), int'(mode)));
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input int a, input int b, input int m);
    int n;
    in_valid = 1'b1;
    exp_a = 6'(a);
    exp_b = 6'(b);
    mode = 2'(m);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe with out_ready=1: checks 2-cycle latency and values.
  task automatic single(input int a, input int b, input int m,
                        input int e_exp, input int e_ovf, input int e_unf, input int e_wrap);
    send(a, b, m);
    @(negedge clk);
    chk("latency_not_early", int'(out_valid), 0);
    @(negedge clk);
    chk("latency_valid", int'(out_valid), 1);
    chk("lit_exp_out", int'(exp_out), e_exp);
    chk("lit_ovf", int'(ovf), e_ovf);
    chk("lit_unf", int'(unf), e_unf);
    chk("lit_exp_out_wrap", int'(exp_out0), e_wrap);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset state, before any clock edge.
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ovf_cnt", int'(ovf_cnt), 0);
    chk("rst_exp_out", int'(exp_out), 0);
    chk("rst_flags", int'(ovf | unf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Directed literal cases.
    single(20, 18, 2, 23, 0, 0, 23);
    single(5, 9, 1, 0, 0, 1, 60);
    single(63, 63, 0, 63, 1, 0, 62);
    chk("cnt_after_first_ovf", int'(ovf_cnt), 2);
    single(60, 0, 3, 63, 1, 0, 11);
    chk("cnt_after_div_ovf", int'(ovf_cnt), 3);
    single(7, 8, 0, 15, 0, 0, 15);

    // Stall: three back-to-back beats with the sink blocked for 4 cycles.
    delivered.delete();
    out_ready = 1'b0;
    send(1, 1, 0);
    send(2, 2, 0);
    in_valid = 1'b1;
    exp_a = 6'd3;
    exp_b = 6'd3;
    mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_hold", int'(exp_out), 2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(4);
    chk("stall_count", delivered.size(), 3);
    seen = (delivered.size() > 0) ? delivered[0] : -1;
    chk("stall_order0", seen, 2);
    seen = (delivered.size() > 1) ? delivered[1] : -1;
    chk("stall_order1", seen, 4);
    seen = (delivered.size() > 2) ? delivered[2] : -1;
    chk("stall_order2", seen, 6);

    // Counter saturation at full throughput, then clear against a same-cycle increment.
    for (int i = 0; i < 260; i++) send(63, 63, 0);
    idle(4);
    chk("cnt_saturated", int'(ovf_cnt), 255);
    send(62, 63, 0);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_same_cycle_delivery", int'(out_valid && ovf), 1);
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_cleared", int'(ovf_cnt), 0);

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      exp_a     = 6'($urandom_range(0, 63));
      exp_b     = 6'($urandom_range(0, 63));
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      cnt_clr   = ($urandom_range(0, 99) == 0);
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("drain_empty", exp_q.size(), 0);

    // Mid-cycle asynchronous reset with both stages full and a nonzero counter.
    single(50, 40, 0, 63, 1, 0, 26);
    out_ready = 1'b0;
    send(10, 10, 0);
    send(11, 11, 0);
    @(posedge clk);
    #2;
    chk("prereset_full", int'(out_valid), 1);
    chk("prereset_cnt_nonzero", int'(ovf_cnt != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_ovf_cnt", int'(ovf_cnt), 0);
    chk("async_exp_out", int'(exp_out), 0);
    chk("async_in_ready", int'(in_ready), 1);
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    single(7, 8, 0, 15, 0, 0, 15);
    idle(2);
    chk("final_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_addsub_pipe.md
EXP_ADDSUB_PIPE -- requirements
Module: exp_addsub_pipe

Interface
REQ-001 The module SHALL have parameter EXP_W, default 6, exponent operand/result width in bits (legal range 4..10).
REQ-002 The module SHALL have parameter BIAS, default 15, the exponent bias used by the bias modes (legal range 0..2^EXP_W-1).
REQ-003 The module SHALL have parameter SAT, default 1, where 1 clamps out-of-range results and 0 wraps them.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit, operand beat valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit, operand beat accepted when high together with in_valid.
REQ-008 The module SHALL have ports exp_a and exp_b, input, EXP_W bits each, unsigned exponent operands.
REQ-009 The module SHALL have port mode, input, 2 bits: 00 = a+b; 01 = a-b; 10 = a+b-BIAS (multiply); 11 = a-b+BIAS (divide).
REQ-010 The module SHALL have port out_valid, output, 1 bit, result beat valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit, downstream accepts result when high together with out_valid.
REQ-012 The module SHALL have port exp_out, output, EXP_W bits, the result exponent.
REQ-013 The module SHALL have ports ovf and unf, output, 1 bit each, overflow / underflow flags qualified by out_valid.
REQ-014 The module SHALL have port ovf_cnt, output, 8 bits, saturating count of delivered beats with ovf or unf set.
REQ-015 The module SHALL have port cnt_clr, input, 1 bit, synchronous clear of ovf_cnt.

Function
REQ-016 The datapath SHALL be a two-stage pipeline (S1, S2), each stage holding a valid bit; latency is 2 cycles from accepted input to out_valid with out_ready held high.
REQ-017 S1 SHALL register the raw sum/difference computed in EXP_W+3-bit signed arithmetic: zero-extended a plus zero-extended b (mode 00/10), or a plus ones-complement of b plus carry-in 1 (mode 01/11), together with the mode.
REQ-018 S2 SHALL register adj = raw (modes 00/01), raw-BIAS (mode 10), or raw+BIAS (mode 11), still EXP_W+3-bit signed.
REQ-019 ovf SHALL be 1 when adj > 2^EXP_W-1; unf SHALL be 1 when adj < 0; never both.
REQ-020 With SAT=1, exp_out SHALL be all ones on ovf, zero on unf, else adj[EXP_W-1:0]; with SAT=0, exp_out SHALL be adj[EXP_W-1:0] always, flags still reported.
REQ-021 S2 SHALL load when it is empty or out_ready is high; S1 SHALL load when it is empty or S2 loads; in_ready SHALL equal (S1 empty) or (S2 loads), combinationally, with no other dependence on in_valid.
REQ-022 out_valid, exp_out, ovf and unf SHALL be held stable while out_valid=1 and out_ready=0; no beat is dropped, duplicated or reordered.
REQ-023 Full throughput SHALL be one beat per cycle with out_ready continuously high; simultaneous accept at input and delivery at output in the same cycle SHALL be supported with both stages full.
REQ-024 ovf_cnt SHALL increment by 1 on each cycle where out_valid and out_ready are both 1 and (ovf or unf) is 1, saturating at 255.
REQ-025 cnt_clr SHALL set ovf_cnt to 0 on the next edge and take priority over a same-cycle increment.

Reset
REQ-026 While rst_n=0, both stage valid bits, out_valid, ovf, unf, exp_out and ovf_cnt SHALL be 0 immediately (asynchronously), regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats; in_ready SHALL read 1 while reset is held; first accepted beat after deassertion emerges 2 cycles later.

Verification (EXP_W=6, BIAS=15, SAT=1 unless stated)
REQ-028 Mode 10, a=20, b=18, out_ready=1 -> 2 cycles later out_valid=1, exp_out=23, ovf=0, unf=0.
REQ-029 Mode 01, a=5, b=9 -> exp_out=0, unf=1; repeat with SAT=0 -> exp_out=60, unf=1.
REQ-030 Mode 00, a=63, b=63 -> exp_out=63, ovf=1, ovf_cnt increments 0->1 on delivery; mode 11, a=60, b=0 -> exp_out=63, ovf=1.
REQ-031 Back-to-back 3 beats (mode 00: 1+1, 2+2, 3+3), out_ready=0 for 4 cycles then 1 -> in_ready low after 2 accepted, outputs held at 2 during stall, delivered in order 2, 4, 6 with no loss.
REQ-032 Drive 260 overflowing beats -> ovf_cnt stops at 255; cnt_clr=1 in the same cycle as a further overflowing delivery -> ovf_cnt=0.
REQ-033 Assert rst_n=0 between clock edges with both stages full -> out_valid and ovf_cnt drop to 0 before next edge; after release, a new beat (mode 00, 7+8) -> exp_out=15 after 2 cycles.
